// File: rtl/op_dispatch_sif.sv
// op_dispatch_sif: buffers packed register ops in a small FIFO and dispatches
// them in strict order onto a shared register bus with a per-instance select,
// honouring per-instance busy backpressure and rejecting out-of-range targets.
module op_dispatch_sif #(
  parameter int NUM_SW_INST = 5,
  parameter int ADDR_WIDTH  = 5,
  parameter int W_WIDTH     = 8,
  parameter int ID_WIDTH    = 8,
  parameter int OP_WIDTH    = 32,
  parameter int DEPTH       = 4,
  localparam int IDX_WIDTH  = $clog2(NUM_SW_INST),
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OP_WIDTH-1:0]    op_in,
  input  logic [IDX_WIDTH-1:0]   fifo_idx,
  input  logic                   bcast_in,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic [NUM_SW_INST-1:0] sw_busy,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic [W_WIDTH-1:0]     wr_data,
  output logic                   wr_rd_s,
  output logic [NUM_SW_INST-1:0] sel_en,
  output logic [ID_WIDTH-1:0]    op_id_out,
  output logic                   err_idx,
  output logic [7:0]             drop_cnt,
  output logic [CNT_W-1:0]       pending
);

  localparam int PTR_W     = $clog2(DEPTH);
  localparam int OP_USED_W = ADDR_WIDTH + 1 + W_WIDTH + ID_WIDTH;

  // Parameter sanity: refuse to elaborate with an inconsistent configuration.
  if (OP_WIDTH < OP_USED_W) begin : g_bad_op_width
    $error("op_dispatch_sif: OP_WIDTH too small for the packed op fields");
  end
  if (NUM_SW_INST < 2) begin : g_bad_num_inst
    $error("op_dispatch_sif: NUM_SW_INST must be at least 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("op_dispatch_sif: DEPTH must be a power of two and at least 2");
  end

  // Upper op bits carry no meaning; fold them away explicitly.
  if (OP_WIDTH > OP_USED_W) begin : g_unused_bits
    logic unused_op_bits;
    assign unused_op_bits = ^op_in[OP_WIDTH-1:OP_USED_W];
  end

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr;
    logic [W_WIDTH-1:0]    data;
    logic [ID_WIDTH-1:0]   id;
    logic                  bcast;
    logic [IDX_WIDTH-1:0]  idx;
  } entry_t;

  entry_t                   mem_q [DEPTH];
  entry_t                   mem_d [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [NUM_SW_INST-1:0]   sel_en_q, sel_en_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [W_WIDTH-1:0]       wr_data_q, wr_data_d;
  logic                     wr_rd_s_q, wr_rd_s_d;
  logic [ID_WIDTH-1:0]      op_id_q, op_id_d;
  logic                     err_idx_q, err_idx_d;
  logic [7:0]               drop_cnt_q, drop_cnt_d;

  entry_t                   in_ent;
  entry_t                   head;
  logic                     accept;
  logic                     bad_idx;
  logic                     push;
  logic                     pop;
  logic                     head_free;

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign ready_in = (count_q != CNT_W'(DEPTH));

  // Accept path: decode the incoming op and classify it as queued or rejected.
  always_comb begin
    in_ent.id    = op_in[ID_WIDTH-1:0];
    in_ent.data  = op_in[ID_WIDTH +: W_WIDTH];
    in_ent.wr    = op_in[ID_WIDTH + W_WIDTH];
    in_ent.addr  = op_in[ID_WIDTH + W_WIDTH + 1 +: ADDR_WIDTH];
    in_ent.bcast = bcast_in;
    in_ent.idx   = fifo_idx;
    accept       = valid_in && ready_in;
    bad_idx      = accept && !bcast_in && (int'(fifo_idx) >= NUM_SW_INST);
    push         = accept && !bad_idx;
  end

  // Dispatch decision: the head may leave only when its target(s) are idle.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    head_free = 1'b0;
    if (count_q != '0) begin
      if (head.bcast) head_free = (sw_busy == '0);
      else            head_free = !sw_busy[head.idx];
    end
    pop = head_free;
  end

  // Next-state for the queue storage, pointers, occupancy and drop tracking.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_ent;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    err_idx_d  = bad_idx;
    drop_cnt_d = drop_cnt_q;
    if (bad_idx && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Next-state for the registered bus outputs; the bus fields hold when idle.
  always_comb begin
    sel_en_d  = '0;
    op_id_d   = '0;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    wr_rd_s_d = wr_rd_s_q;
    if (pop) begin
      sel_en_d  = head.bcast ? {NUM_SW_INST{1'b1}}
                             : (NUM_SW_INST'(1) << head.idx);
      op_id_d   = head.id;
      addr_d    = head.addr;
      wr_data_d = head.data;
      wr_rd_s_d = head.wr;
    end
  end

  // Control and output registers; reset discards every queued op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sel_en_q   <= '0;
      op_id_q    <= '0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      wr_rd_s_q  <= 1'b0;
      err_idx_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sel_en_q   <= sel_en_d;
      op_id_q    <= op_id_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      wr_rd_s_q  <= wr_rd_s_d;
      err_idx_q  <= err_idx_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Queue storage is data only; its content is meaningless until written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign sel_en    = sel_en_q;
  assign op_id_out = op_id_q;
  assign addr      = addr_q;
  assign wr_data   = wr_data_q;
  assign wr_rd_s   = wr_rd_s_q;
  assign err_idx   = err_idx_q;
  assign drop_cnt  = drop_cnt_q;
  assign pending   = count_q;

endmodule

// File: tb/tb_op_dispatch_sif.sv
// Scoreboard bench for op_dispatch_sif: a queue-based reference model predicts
// every dispatch, the occupancy and the reject tracking; a monitor compares.
module tb_op_dispatch_sif;

  localparam int NSW   = 5;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op_in;
  logic [2:0]  fifo_idx;
  logic        bcast_in;
  logic        valid_in;
  logic        ready_in;
  logic [4:0]  sw_busy;
  logic [4:0]  addr;
  logic [7:0]  wr_data;
  logic        wr_rd_s;
  logic [4:0]  sel_en;
  logic [7:0]  op_id_out;
  logic        err_idx;
  logic [7:0]  drop_cnt;
  logic [2:0]  pending;

  op_dispatch_sif dut (
    .clk(clk), .rst(rst), .op_in(op_in), .fifo_idx(fifo_idx),
    .bcast_in(bcast_in), .valid_in(valid_in), .ready_in(ready_in),
    .sw_busy(sw_busy), .addr(addr), .wr_data(wr_data), .wr_rd_s(wr_rd_s),
    .sel_en(sel_en), .op_id_out(op_id_out), .err_idx(err_idx),
    .drop_cnt(drop_cnt), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] addr;
    logic       wr;
    logic [7:0] data;
    logic [7:0] id;
    logic       bc;
    logic [2:0] idx;
  } op_t;

  typedef struct {
    logic [4:0] sel;
    logic [4:0] addr;
    logic [7:0] data;
    logic       wr;
    logic [7:0] id;
  } disp_t;

  op_t   mq[$];
  disp_t exp_q[$];
  int    m_pending = 0;
  int    m_drop    = 0;
  logic  m_err     = 1'b0;
  logic [4:0] m_addr = '0;
  logic [7:0] m_data = '0;
  logic       m_wr   = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: ops wait in order; the head leaves when its target is idle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_pending = 0;
      m_drop    = 0;
      m_err     = 1'b0;
      m_addr    = '0;
      m_data    = '0;
      m_wr      = 1'b0;
    end else begin
      bit    go;
      bit    room;
      op_t   h;
      op_t   n;
      disp_t d;
      go   = 0;
      room = (mq.size() != DEPTH);
      if (mq.size() > 0) begin
        h  = mq[0];
        go = h.bc ? (sw_busy == 5'd0) : (sw_busy[h.idx] == 1'b0);
      end
      m_err = 1'b0;
      if (go) begin
        void'(mq.pop_front());
        d.sel  = h.bc ? 5'b11111 : 5'(1 << h.idx);
        d.addr = h.addr;
        d.data = h.data;
        d.wr   = h.wr;
        d.id   = h.id;
        exp_q.push_back(d);
        m_addr = h.addr;
        m_data = h.data;
        m_wr   = h.wr;
      end
      if (valid_in && room) begin
        if (!bcast_in && fifo_idx >= NSW) begin
          m_err = 1'b1;
          if (m_drop < 255) m_drop++;
        end else begin
          n.id   = op_in[7:0];
          n.data = op_in[15:8];
          n.wr   = op_in[16];
          n.addr = op_in[21:17];
          n.bc   = bcast_in;
          n.idx  = fifo_idx;
          mq.push_back(n);
        end
      end
      m_pending = mq.size();
    end
  end

  // Monitor: compare every observable output against the model mid-cycle.
  always @(negedge clk) begin
    disp_t d;
    if (sel_en != 5'd0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dispatch", {27'd0, sel_en}, 32'd0);
      end else begin
        d = exp_q.pop_front();
        chk("sel_en",    {27'd0, sel_en},    {27'd0, d.sel});
        chk("op_id_out", {24'd0, op_id_out}, {24'd0, d.id});
        chk("wr_data",   {24'd0, wr_data},   {24'd0, d.data});
        chk("wr_rd_s",   {31'd0, wr_rd_s},   {31'd0, d.wr});
      end
    end else begin
      if (exp_q.size() != 0) begin
        d = exp_q.pop_front();
        chk("missing_dispatch", {27'd0, sel_en}, {27'd0, d.sel});
      end
      chk("op_id_idle", {24'd0, op_id_out}, 32'd0);
    end
    chk("addr_bus",  {27'd0, addr},     {27'd0, m_addr});
    chk("data_bus",  {24'd0, wr_data},  {24'd0, m_data});
    chk("wr_bus",    {31'd0, wr_rd_s},  {31'd0, m_wr});
    chk("pending",   {29'd0, pending},  32'(m_pending));
    chk("ready_in",  {31'd0, ready_in}, {31'd0, (m_pending != DEPTH)});
    chk("err_idx",   {31'd0, err_idx},  {31'd0, m_err});
    chk("drop_cnt",  {24'd0, drop_cnt}, 32'(m_drop));
  end

  function automatic logic [31:0] mk_op(input logic [4:0] a, input logic w,
                                        input logic [7:0] dt, input logic [7:0] id);
    logic [31:0] r;
    r        = $urandom;
    r[21:0]  = {a, w, dt, id};
    return r;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [4:0] a, input logic w, input logic [7:0] dt,
                      input logic [7:0] id, input logic [2:0] idx, input logic bc);
    int n;
    op_in    = mk_op(a, w, dt, id);
    fifo_idx = idx;
    bcast_in = bc;
    valid_in = 1'b1;
    n = 0;
    while (!ready_in && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic idle(input int cyc);
    valid_in = 1'b0;
    repeat (cyc) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    op_in    = '0;
    fifo_idx = '0;
    bcast_in = 1'b0;
    valid_in = 1'b0;
    sw_busy  = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready",   {31'd0, ready_in}, 32'd1);
    chk("rst_pending", {29'd0, pending},  32'd0);
    chk("rst_sel",     {27'd0, sel_en},   32'd0);
    chk("rst_drop",    {24'd0, drop_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single write op to instance 3.
    send(5'h0A, 1'b1, 8'h5C, 8'h21, 3'd3, 1'b0);
    idle(4);

    // Backpressure: instance 1 busy while five ops target it.
    sw_busy = 5'b00010;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(5'(i + 1), 1'b1, 8'(8'h10 + i), 8'(8'h40 + i), 3'd1, 1'b0);
        valid_in = 1'b0;
      end
      begin
        repeat (10) @(negedge clk);
        chk("full_pending", {29'd0, pending},  32'd4);
        chk("full_ready",   {31'd0, ready_in}, 32'd0);
        sw_busy = 5'b00000;
      end
    join
    idle(8);
    chk("drained_pending", {29'd0, pending}, 32'd0);

    // Head-of-line blocking.
    sw_busy = 5'b00001;
    send(5'h03, 1'b0, 8'hA1, 8'h51, 3'd0, 1'b0);
    send(5'h04, 1'b1, 8'hA2, 8'h52, 3'd2, 1'b0);
    idle(4);
    sw_busy = 5'b00000;
    idle(5);

    // Broadcast waiting on one busy instance.
    sw_busy = 5'b00100;
    send(5'h1F, 1'b1, 8'hEE, 8'h77, 3'd6, 1'b1);
    idle(4);
    sw_busy = 5'b00000;
    idle(4);

    // Invalid index rejection and counter saturation.
    send(5'h01, 1'b1, 8'h01, 8'h01, 3'd6, 1'b0);
    idle(3);
    chk("drop_one", {24'd0, drop_cnt}, 32'd1);
    for (int i = 0; i < 259; i++)
      send(5'(i), 1'b0, 8'(i), 8'(i), 3'($urandom_range(5, 7)), 1'b0);
    idle(3);
    chk("drop_sat", {24'd0, drop_cnt}, 32'd255);

    // Reset with ops queued behind busy instances.
    sw_busy = 5'b11111;
    for (int i = 0; i < 3; i++)
      send(5'(i + 8), 1'b1, 8'(8'hC0 + i), 8'(8'h90 + i), 3'(i), 1'b0);
    idle(1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_pending", {29'd0, pending},  32'd0);
    chk("mid_rst_sel",     {27'd0, sel_en},   32'd0);
    chk("mid_rst_drop",    {24'd0, drop_cnt}, 32'd0);
    chk("mid_rst_addr",    {27'd0, addr},     32'd0);
    @(negedge clk);
    rst     = 1'b0;
    sw_busy = 5'b00000;
    idle(6);

    // Randomised traffic with random busy patterns.
    for (int c = 0; c < 800; c++) begin
      sw_busy  = 5'($urandom & $urandom);
      valid_in = ($urandom_range(0, 3) != 0);
      op_in    = $urandom;
      bcast_in = ($urandom_range(0, 7) == 0);
      fifo_idx = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                             : 3'($urandom_range(0, 4));
      @(negedge clk);
    end
    sw_busy = 5'b00000;
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
